// File: rtl/tipi_pkg.sv
// tipi_pkg: shared width, select/direction encodings and FSM states for the TIPI RPi shifter.
package tipi_pkg;
  localparam int TIPI_WIDTH = 8;
  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_CTRL = 1'b1;
  localparam logic DIR_WRITE = 1'b0;
  localparam logic DIR_READ = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;
endpackage

// File: rtl/tipi_sync_edge.sv
// tipi_sync_edge: one-bit synchroniser chain with a rising-edge pulse on the synced level.
module tipi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [SYNC_STAGES-1:0] chain;
  logic prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev <= chain[SYNC_STAGES-1];
    end
  end
  assign q = chain[SYNC_STAGES-1];
  assign rise = q & ~prev;
endmodule

// File: rtl/tipi_rpi_shifter.sv
// tipi_rpi_shifter: GPIO serial shifter between the TI-side latches and the Raspberry Pi.
module tipi_rpi_shifter
  import tipi_pkg::*;
#(
  parameter int WIDTH = TIPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r_clk,
  input  logic             r_din,
  output logic             r_dout,
  input  logic             r_cd,
  input  logic             r_rt,
  input  logic             r_le,
  input  logic [WIDTH-1:0] ti_td,
  input  logic [WIDTH-1:0] ti_tc,
  output logic [WIDTH-1:0] rd_q,
  output logic [WIDTH-1:0] rc_q,
  output logic             rd_strobe,
  output logic             rc_strobe,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic clk_rise, le_rise, din_sync, cd_sync, rt_sync;
  logic unused_clk_q, unused_le_q, unused_din_rise, unused_cd_rise, unused_rt_rise;
  logic [WIDTH-1:0] td_s0, td_s1, td_s2, tc_s0, tc_s1, tc_s2, td_snap, tc_snap, shreg;
  logic [CW-1:0] count;
  state_t state;
  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk (.clk(clk), .rst_n(rst_n), .d(r_clk), .q(unused_clk_q), .rise(clk_rise));
  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_le  (.clk(clk), .rst_n(rst_n), .d(r_le),  .q(unused_le_q),  .rise(le_rise));
  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_din (.clk(clk), .rst_n(rst_n), .d(r_din), .q(din_sync), .rise(unused_din_rise));
  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cd  (.clk(clk), .rst_n(rst_n), .d(r_cd),  .q(cd_sync),  .rise(unused_cd_rise));
  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rt  (.clk(clk), .rst_n(rst_n), .d(r_rt),  .q(rt_sync),  .rise(unused_rt_rise));
  // Snapshots only follow a TI byte seen identical on two consecutive synced samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      td_s0 <= '0;
      td_s1 <= '0;
      td_s2 <= '0;
      tc_s0 <= '0;
      tc_s1 <= '0;
      tc_s2 <= '0;
      td_snap <= '0;
      tc_snap <= '0;
    end else begin
      td_s0 <= ti_td;
      td_s1 <= td_s0;
      td_s2 <= td_s1;
      tc_s0 <= ti_tc;
      tc_s1 <= tc_s0;
      tc_s2 <= tc_s1;
      if (td_s1 == td_s2) td_snap <= td_s1;
      if (tc_s1 == tc_s2) tc_snap <= tc_s1;
    end
  end
  // A latch edge takes priority over a coincident shift edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      rd_q <= '0;
      rc_q <= '0;
      rd_strobe <= 1'b0;
      rc_strobe <= 1'b0;
      overrun <= 1'b0;
      count <= '0;
      state <= IDLE;
    end else begin
      rd_strobe <= 1'b0;
      rc_strobe <= 1'b0;
      if (le_rise) begin
        if (rt_sync == DIR_READ) shreg <= (cd_sync == SEL_CTRL) ? tc_snap : td_snap;
        else if (cd_sync == SEL_CTRL) begin
          rc_q <= shreg;
          rc_strobe <= 1'b1;
        end else begin
          rd_q <= shreg;
          rd_strobe <= 1'b1;
        end
        state <= SHIFT;
        count <= '0;
        overrun <= 1'b0;
      end else if (clk_rise) begin
        shreg <= {shreg[WIDTH-2:0], din_sync};
        if (state == FULL) overrun <= 1'b1;
        else begin
          count <= count + 1'b1;
          state <= (count + 1'b1 == CW'(WIDTH)) ? FULL : SHIFT;
        end
      end
    end
  end
  assign r_dout = shreg[WIDTH-1];
endmodule

// File: tb/tb_tipi_rpi_shifter.sv
// tb_tipi_rpi_shifter: directed scenario tests for the TIPI RPi shifter.
`timescale 1ns/1ps
module tb_tipi_rpi_shifter;
  import tipi_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic r_clk = 1'b0, r_din = 1'b0, r_cd = 1'b0, r_rt = 1'b0, r_le = 1'b0;
  logic r_dout, rd_strobe, rc_strobe, overrun;
  logic [7:0] ti_td = 8'h00, ti_tc = 8'h00, rd_q, rc_q, v;
  int tests = 0, fails = 0;
  tipi_rpi_shifter dut (
    .clk(clk), .rst_n(rst_n), .r_clk(r_clk), .r_din(r_din), .r_dout(r_dout),
    .r_cd(r_cd), .r_rt(r_rt), .r_le(r_le), .ti_td(ti_td), .ti_tc(ti_tc),
    .rd_q(rd_q), .rc_q(rc_q), .rd_strobe(rd_strobe), .rc_strobe(rc_strobe), .overrun(overrun)
  );
  always #10 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clk_pulse(input logic b);
    r_din = b;
    r_clk = 1'b1;
    cyc(4);
    r_clk = 1'b0;
    cyc(4);
  endtask
  task automatic le_pulse;
    r_le = 1'b1;
    cyc(4);
    r_le = 1'b0;
    cyc(4);
  endtask
  task automatic shift_out(output logic [7:0] o);
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o = {o[6:0], r_dout};
      clk_pulse(1'b0);
    end
  endtask
  task automatic shift_in(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) clk_pulse(d[i]);
  endtask
  task automatic test_reset;
    cyc(3);
    tests++;
    if ({r_dout, rd_q, rc_q, rd_strobe, rc_strobe, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_hold: got dout=%b rd=%h rc=%h strb=%b%b ovr=%b want all 0", r_dout, rd_q, rc_q, rd_strobe, rc_strobe, overrun);
    end
    rst_n = 1'b1;
    cyc(2);
    tests++;
    if ({r_dout, rd_q, rc_q, overrun} !== '0 || dut.state !== IDLE) begin
      fails++;
      $display("FAIL reset_release: got dout=%b rd=%h rc=%h ovr=%b state=%0d want 0s, IDLE", r_dout, rd_q, rc_q, overrun, dut.state);
    end
  endtask
  task automatic test_read_data;
    logic [7:0] exp;
    exp = 8'hA5;
    ti_td = exp;
    ti_tc = 8'h96;
    cyc(5);
    r_rt = DIR_READ;
    r_cd = SEL_DATA;
    r_le = 1'b1;
    cyc(2);
    tests++;
    if (r_dout !== 1'b0) begin
      fails++;
      $display("FAIL read_latency_early: got %b want 0", r_dout);
    end
    cyc(1);
    tests++;
    if (r_dout !== 1'b1) begin
      fails++;
      $display("FAIL read_latency_3clk: got %b want 1", r_dout);
    end
    r_le = 1'b0;
    cyc(4);
    for (int i = 7; i >= 0; i--) begin
      tests++;
      if (r_dout !== exp[i]) begin
        fails++;
        $display("FAIL read_bit%0d: got %b want %b", i, r_dout, exp[i]);
      end
      clk_pulse(1'b0);
    end
    r_cd = SEL_CTRL;
    le_pulse();
    shift_out(v);
    tests++;
    if (v !== 8'h96) begin
      fails++;
      $display("FAIL read_ctrl: got %h want 96", v);
    end
  endtask
  task automatic test_write;
    int nrc, nrd;
    r_rt = DIR_WRITE;
    r_cd = SEL_CTRL;
    shift_in(8'h3C);
    nrc = 0;
    nrd = 0;
    r_le = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      nrc += int'(rc_strobe);
      nrd += int'(rd_strobe);
      if (i == 3) r_le = 1'b0;
    end
    tests++;
    if (rc_q !== 8'h3C || nrc != 1) begin
      fails++;
      $display("FAIL write_ctrl: got rc=%h strobe_clks=%0d want 3c, 1", rc_q, nrc);
    end
    tests++;
    if (rd_q !== 8'h00 || nrd != 0) begin
      fails++;
      $display("FAIL write_ctrl_rd_untouched: got rd=%h strobe_clks=%0d want 00, 0", rd_q, nrd);
    end
    r_cd = SEL_DATA;
    shift_in(8'h81);
    le_pulse();
    tests++;
    if (rd_q !== 8'h81 || rc_q !== 8'h3C) begin
      fails++;
      $display("FAIL write_data: got rd=%h rc=%h want 81, 3c", rd_q, rc_q);
    end
  endtask
  task automatic test_overrun;
    ti_td = 8'hFF;
    cyc(6);
    r_rt = DIR_READ;
    r_cd = SEL_DATA;
    le_pulse();
    for (int i = 0; i < 8; i++) clk_pulse(1'b0);
    tests++;
    if (overrun !== 1'b0 || dut.state !== FULL) begin
      fails++;
      $display("FAIL overrun_8: got ovr=%b state=%0d want 0, FULL", overrun, dut.state);
    end
    clk_pulse(1'b0);
    tests++;
    if (overrun !== 1'b1 || dut.count !== 4'd8) begin
      fails++;
      $display("FAIL overrun_9: got ovr=%b count=%0d want 1, 8", overrun, dut.count);
    end
    le_pulse();
    tests++;
    if (overrun !== 1'b0 || dut.state !== SHIFT || dut.count !== 4'd0) begin
      fails++;
      $display("FAIL overrun_clear: got ovr=%b state=%0d count=%0d want 0, SHIFT, 0", overrun, dut.state, dut.count);
    end
  endtask
  task automatic test_unstable;
    ti_td = 8'hC3;
    cyc(6);
    r_rt = DIR_READ;
    r_cd = SEL_DATA;
    for (int i = 0; i < 20; i++) begin
      ti_td = i[0] ? 8'hFF : 8'h00;
      if (i == 4) r_le = 1'b1;
      if (i == 10) r_le = 1'b0;
      cyc(1);
    end
    ti_td = 8'h5A;
    cyc(4);
    shift_out(v);
    tests++;
    if (v !== 8'hC3) begin
      fails++;
      $display("FAIL unstable_during_toggle: got %h want c3", v);
    end
    le_pulse();
    shift_out(v);
    tests++;
    if (v !== 8'h5A) begin
      fails++;
      $display("FAIL unstable_settled: got %h want 5a", v);
    end
  endtask
  task automatic test_collision;
    ti_td = 8'h69;
    cyc(6);
    r_rt = DIR_READ;
    r_cd = SEL_DATA;
    r_din = 1'b1;
    r_le = 1'b1;
    r_clk = 1'b1;
    cyc(4);
    tests++;
    if (dut.shreg !== 8'h69 || dut.count !== 4'd0) begin
      fails++;
      $display("FAIL collision_load: got shreg=%h count=%0d want 69, 0", dut.shreg, dut.count);
    end
    r_le = 1'b0;
    r_clk = 1'b0;
    cyc(4);
    shift_out(v);
    tests++;
    if (v !== 8'h69) begin
      fails++;
      $display("FAIL collision_readout: got %h want 69", v);
    end
  endtask
  task automatic test_reset_mid;
    ti_td = 8'hFF;
    cyc(6);
    r_rt = DIR_READ;
    r_cd = SEL_DATA;
    le_pulse();
    for (int i = 0; i < 4; i++) clk_pulse(1'b1);
    tests++;
    if (r_dout !== 1'b1 || rd_q !== 8'h81) begin
      fails++;
      $display("FAIL premid_state: got dout=%b rd=%h want 1, 81", r_dout, rd_q);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({r_dout, rd_q, rc_q, rd_strobe, rc_strobe, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_async: got dout=%b rd=%h rc=%h strb=%b%b ovr=%b want all 0", r_dout, rd_q, rc_q, rd_strobe, rc_strobe, overrun);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    tests++;
    if (dut.state !== IDLE || dut.count !== 4'd0 || r_dout !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_release: got state=%0d count=%0d dout=%b want IDLE, 0, 0", dut.state, dut.count, r_dout);
    end
  endtask
  initial begin
    test_reset();
    test_read_data();
    test_write();
    test_overrun();
    test_unstable();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
